// File: rtl/axi_lite_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the single-port request scheduler:
//   - state_e        : scheduler FSM encoding
//   - REGn_START/END : inclusive SoC address-map regions
//   - decode_region  : address -> one-hot region select (0 when unmapped)
// No ports (package).
// -----------------------------------------------------------------------------
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2,
    DELIVER = 2'd3
  } state_e;

  localparam int NB_REGION = 3;

  localparam logic [31:0] REG0_START = 32'h0000_0000;  // instr RAM
  localparam logic [31:0] REG0_END   = 32'h000F_FFFF;
  localparam logic [31:0] REG1_START = 32'h0010_0000;  // data RAM
  localparam logic [31:0] REG1_END   = 32'h001F_FFFF;
  localparam logic [31:0] REG2_START = 32'h1A10_0000;  // peripherals
  localparam logic [31:0] REG2_END   = 32'h1A11_FFFF;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  function automatic logic [NB_REGION-1:0] decode_region(input logic [31:0] addr);
    logic [NB_REGION-1:0] sel;
    sel    = '0;
    sel[0] = in_range(addr, REG0_START, REG0_END);
    sel[1] = in_range(addr, REG1_START, REG1_END);
    sel[2] = in_range(addr, REG2_START, REG2_END);
    return sel;
  endfunction

endpackage

// File: rtl/axi_lite_req_sched_if.sv
// -----------------------------------------------------------------------------
// axi_lite_req_sched_if
// Bundles the requester side and the slave side of the scheduler.
//   modport slave  : the scheduler's view (it serves the requesters)
//   modport master : the environment's view (requesters + memory slave)
// Signals:
//   req_*      : per-master packed request channel (master k in slice k)
//   resp_*     : response channel back to the owning master
//   slv_*      : single shared slave port, one-hot region select
//   stray_resp_o : pulse when a slave response arrives with nothing waiting
// -----------------------------------------------------------------------------
interface axi_lite_req_sched_if #(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NB_MASTER-1:0]            req_valid_i;
  logic [NB_MASTER-1:0]            req_ready_o;
  logic [NB_MASTER*ADDR_WIDTH-1:0] req_addr_i;
  logic [NB_MASTER-1:0]            req_we_i;
  logic [NB_MASTER*DATA_WIDTH-1:0] req_wdata_i;
  logic [NB_MASTER-1:0]            resp_valid_o;
  logic [NB_MASTER-1:0]            resp_ready_i;
  logic [DATA_WIDTH-1:0]           resp_rdata_o;
  logic                            resp_err_o;
  logic                            slv_req_valid_o;
  logic                            slv_req_ready_i;
  logic [NB_SLAVE-1:0]             slv_sel_o;
  logic [ADDR_WIDTH-1:0]           slv_addr_o;
  logic                            slv_we_o;
  logic [DATA_WIDTH-1:0]           slv_wdata_o;
  logic                            slv_resp_valid_i;
  logic                            slv_resp_ready_o;
  logic [DATA_WIDTH-1:0]           slv_rdata_i;
  logic                            slv_err_i;
  logic                            stray_resp_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
           slv_req_ready_i, slv_resp_valid_i, slv_rdata_i, slv_err_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           slv_req_valid_o, slv_sel_o, slv_addr_o, slv_we_o, slv_wdata_o,
           slv_resp_ready_o, stray_resp_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
           slv_req_ready_i, slv_resp_valid_i, slv_rdata_i, slv_err_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           slv_req_valid_o, slv_sel_o, slv_addr_o, slv_we_o, slv_wdata_o,
           slv_resp_ready_o, stray_resp_o
  );
endinterface

// File: rtl/axi_lite_req_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request at or above i_ptr,
// wrapping from N-1 back to 0.
//   i_req     : request vector
//   i_ptr     : highest-priority index this cycle
//   i_en      : arbitration enable (no grant when low)
//   o_gnt     : one-hot grant
//   o_gnt_idx : binary index of the grant
//   o_any     : a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);
  logic w_found;
  int   w_k;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(i_ptr) + i) % N;
      if (i_en && !w_found && i_req[w_k]) begin
        o_gnt[w_k] = 1'b1;
        o_gnt_idx  = IDX_W'(w_k);
        w_found    = 1'b1;
      end
    end
    o_any = w_found;
  end
endmodule

// File: rtl/axi_lite_req_sched.sv
// -----------------------------------------------------------------------------
// axi_lite_req_sched
// Shares one single-beat slave port among NB_MASTER requesters with
// round-robin arbitration, address decode to a one-hot region select,
// one transaction in flight, error responses for unmapped addresses and
// for slave timeouts.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : axi_lite_req_sched_if.slave (request, response and slave channels)
// -----------------------------------------------------------------------------
module axi_lite_req_sched
  import sched_pkg::*;
#(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_req_sched_if.slave    bus
);
  localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_REQ     = REQ;
  localparam logic [1:0] ST_RESP    = RESP;
  localparam logic [1:0] ST_DELIVER = DELIVER;

  localparam logic [NB_MASTER-1:0] ONE_M = NB_MASTER'(1);

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB_SLAVE-1:0]   r_sel;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic [NB_MASTER-1:0]  w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic                  w_arb_en;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_wdata;
  logic [NB_SLAVE-1:0]   w_dec;

  // Gating with rst keeps req_ready_o low while reset is held, even though
  // the state register already reads IDLE.
  assign w_arb_en = (r_state == ST_IDLE) && !rst;

  rr_arbiter #(.N(NB_MASTER), .IDX_W(IDX_W)) u_arb (
    .i_req     (bus.req_valid_i),
    .i_ptr     (r_ptr),
    .i_en      (w_arb_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_ptr_nxt   = (w_gnt_idx == IDX_W'(NB_MASTER - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
  assign w_gnt_addr  = bus.req_addr_i[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_gnt_wdata = bus.req_wdata_i[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_dec       = NB_SLAVE'(decode_region(32'(w_gnt_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_addr  <= w_gnt_addr;
            r_we    <= bus.req_we_i[w_gnt_idx];
            r_wdata <= w_gnt_wdata;
            r_owner <= w_gnt_idx;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_dec;
            if (|w_dec) begin
              r_state <= ST_REQ;
            end else begin
              // Unmapped: answer directly without touching the slave port.
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= ST_DELIVER;
            end
          end
        end
        ST_REQ: begin
          if (bus.slv_req_ready_i) begin
            r_cnt   <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A response arriving on the timeout cycle takes precedence.
          if (bus.slv_resp_valid_i) begin
            r_rdata <= bus.slv_rdata_i;
            r_err   <= bus.slv_err_i;
            r_state <= ST_DELIVER;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= ST_DELIVER;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (bus.resp_ready_i[r_owner]) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o      = w_gnt;
  assign bus.resp_valid_o     = (r_state == ST_DELIVER) ? (ONE_M << r_owner) : '0;
  assign bus.resp_rdata_o     = r_rdata;
  assign bus.resp_err_o       = r_err;
  assign bus.slv_req_valid_o  = (r_state == ST_REQ);
  assign bus.slv_sel_o        = (r_state == ST_REQ) ? r_sel : '0;
  assign bus.slv_addr_o       = r_addr;
  assign bus.slv_we_o         = r_we;
  assign bus.slv_wdata_o      = r_wdata;
  // Only REQ refuses responses; everywhere else they are drained.
  assign bus.slv_resp_ready_o = (r_state != ST_REQ);
  assign bus.stray_resp_o     = bus.slv_resp_valid_i && !rst &&
                                ((r_state == ST_IDLE) || (r_state == ST_DELIVER));
endmodule

// File: tb/tb_axi_lite_req_sched.sv
module tb_axi_lite_req_sched;
  localparam int NM = 3;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_req_sched_if #(.NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  axi_lite_req_sched #(
    .NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned   m;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [AW-1:0] a_tab [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned m, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.m = m; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_resp(input string tag, input bit pop);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL %s: observed resp_valid %0h expected none queued", tag, bus.resp_valid_o);
    end else begin
      e = sb[0];
      chk({tag, "_valid"}, 64'(bus.resp_valid_o), 64'(1) << e.m);
      chk({tag, "_rdata"}, 64'(bus.resp_rdata_o), 64'(e.rdata));
      chk({tag, "_err"},   64'(bus.resp_err_o),   64'(e.err));
      if (pop) void'(sb.pop_front());
    end
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] addr, input logic we,
                         input logic [DW-1:0] wdata);
    bus.req_addr_i[m*AW +: AW]  = addr;
    bus.req_we_i[m]             = we;
    bus.req_wdata_i[m*DW +: DW] = wdata;
  endtask

  initial begin
    int e;
    rst = 1'b1;
    bus.req_valid_i      = '0;
    bus.req_addr_i       = '0;
    bus.req_we_i         = '0;
    bus.req_wdata_i      = '0;
    bus.resp_ready_i     = '1;
    bus.slv_req_ready_i  = 1'b1;
    bus.slv_resp_valid_i = 1'b0;
    bus.slv_rdata_i      = '0;
    bus.slv_err_i        = 1'b0;
    #2;
    // Reset state
    chk("rst_req_ready",  64'(bus.req_ready_o), 64'(0));
    chk("rst_slv_valid",  64'(bus.slv_req_valid_o), 64'(0));
    chk("rst_sel",        64'(bus.slv_sel_o), 64'(0));
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'(0));
    chk("rst_resp_ready", 64'(bus.slv_resp_ready_o), 64'(1));
    chk("rst_rdata",      64'(bus.resp_rdata_o), 64'(0));
    chk("rst_addr",       64'(bus.slv_addr_o), 64'(0));
    chk("rst_stray",      64'(bus.stray_resp_o), 64'(0));
    tick();
    rst = 1'b0;

    // Round-robin order with all three requesting, zero-wait slave
    a_tab[0] = 32'h0000_0100;
    a_tab[1] = 32'h0010_0040;
    a_tab[2] = 32'h0000_0200;
    for (int i = 0; i < 3; i++) set_req(i, a_tab[i], 1'b0, '0);
    bus.req_valid_i = 3'b111;
    for (int n = 0; n < 4; n++) begin
      e = n % 3;
      #1;
      chk("t1_grant", 64'(bus.req_ready_o), 64'(1) << e);
      push(e, 32'hA000_0000 + n, 1'b0);
      tick();
      chk("t1_slv_req_valid", 64'(bus.slv_req_valid_o), 64'(1));
      chk("t1_slv_addr", 64'(bus.slv_addr_o), 64'(a_tab[e]));
      tick();
      bus.slv_resp_valid_i = 1'b1;
      bus.slv_rdata_i      = 32'hA000_0000 + n;
      tick();
      bus.slv_resp_valid_i = 1'b0;
      check_resp("t1_resp", 1'b1);
      tick();
    end
    bus.req_valid_i = '0;

    // Decode to the peripheral region
    set_req(1, 32'h1A10_0004, 1'b0, '0);
    bus.req_valid_i = 3'b010;
    #1;
    chk("t2_grant", 64'(bus.req_ready_o), 64'(3'b010));
    push(1, 32'hDEAD_BEEF, 1'b0);
    tick();
    bus.req_valid_i = '0;
    chk("t2_sel", 64'(bus.slv_sel_o), 64'(3'b100));
    tick();
    bus.slv_resp_valid_i = 1'b1;
    bus.slv_rdata_i      = 32'hDEAD_BEEF;
    tick();
    bus.slv_resp_valid_i = 1'b0;
    check_resp("t2_resp", 1'b1);
    tick();

    // Unmapped write
    set_req(2, 32'h2000_0000, 1'b1, 32'h5555_AAAA);
    bus.req_valid_i = 3'b100;
    #1;
    chk("t3_grant", 64'(bus.req_ready_o), 64'(3'b100));
    push(2, '0, 1'b1);
    tick();
    bus.req_valid_i = '0;
    chk("t3_no_slv_req", 64'(bus.slv_req_valid_o), 64'(0));
    check_resp("t3_resp", 1'b1);
    tick();

    // Timeout, then a late stray response
    set_req(0, 32'h0000_0010, 1'b0, '0);
    bus.req_valid_i = 3'b001;
    #1;
    chk("t4_grant", 64'(bus.req_ready_o), 64'(3'b001));
    push(0, '0, 1'b1);
    tick();
    bus.req_valid_i = '0;
    tick();
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("t4_wait", 64'(bus.resp_valid_o), 64'(0));
    end
    tick();
    check_resp("t4_timeout", 1'b1);
    tick();
    tick();
    bus.slv_resp_valid_i = 1'b1;
    #1;
    chk("t4_stray_pulse", 64'(bus.stray_resp_o), 64'(1));
    tick();
    bus.slv_resp_valid_i = 1'b0;
    #1;
    chk("t4_stray_clear", 64'(bus.stray_resp_o), 64'(0));

    // Slave request backpressure
    bus.slv_req_ready_i = 1'b0;
    set_req(2, 32'h0010_0008, 1'b1, 32'h1234_5678);
    bus.req_valid_i = 3'b100;
    #1;
    chk("t5_grant", 64'(bus.req_ready_o), 64'(3'b100));
    push(2, 32'hCAFE_0000, 1'b1);
    tick();
    bus.req_valid_i = '0;
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_valid", 64'(bus.slv_req_valid_o), 64'(1));
      chk("t5_hold_addr",  64'(bus.slv_addr_o), 64'(32'h0010_0008));
      chk("t5_hold_sel",   64'(bus.slv_sel_o), 64'(3'b010));
      chk("t5_hold_we",    64'(bus.slv_we_o), 64'(1));
      chk("t5_hold_wdata", 64'(bus.slv_wdata_o), 64'(32'h1234_5678));
      tick();
    end
    bus.slv_req_ready_i = 1'b1;
    tick();
    bus.slv_resp_valid_i = 1'b1;
    bus.slv_rdata_i      = 32'hCAFE_0000;
    bus.slv_err_i        = 1'b1;
    tick();
    bus.slv_resp_valid_i = 1'b0;
    bus.slv_err_i        = 1'b0;
    // Response backpressure: held, no new grant
    bus.resp_ready_i = '0;
    set_req(0, 32'h0000_0400, 1'b0, '0);
    bus.req_valid_i = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_resp("t5_resp_hold", 1'b0);
      chk("t5_no_grant", 64'(bus.req_ready_o), 64'(0));
      tick();
    end
    bus.resp_ready_i = '1;
    #1;
    check_resp("t5_resp", 1'b1);
    tick();
    chk("t5_next_grant", 64'(bus.req_ready_o), 64'(3'b001));

    // Reset while waiting for the slave response
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_resp_valid",  64'(bus.resp_valid_o), 64'(0));
    chk("t6_slv_valid",   64'(bus.slv_req_valid_o), 64'(0));
    chk("t6_sel",         64'(bus.slv_sel_o), 64'(0));
    chk("t6_resp_ready",  64'(bus.slv_resp_ready_o), 64'(1));
    chk("t6_req_ready",   64'(bus.req_ready_o), 64'(0));
    chk("t6_addr",        64'(bus.slv_addr_o), 64'(0));
    chk("t6_rdata",       64'(bus.resp_rdata_o), 64'(0));
    chk("t6_err",         64'(bus.resp_err_o), 64'(0));
    chk("t6_we",          64'(bus.slv_we_o), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    bus.req_valid_i = 3'b111;
    #1;
    chk("t6_rr_restart", 64'(bus.req_ready_o), 64'(3'b001));
    bus.req_valid_i = '0;
    chk("end_sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axi_lite_req_sched.md
Name: axi_lite_req_sched

Overview:
- Round-robin scheduler that shares one single-beat register/memory port between NB_MASTER requesters (core data, debug, SPI-slave loader).
- Decodes each granted address against the SoC map (instr RAM, data RAM, peripherals) and drives a one-hot slave select.
- Keeps one transaction in flight at a time.
- Generates error responses for unmapped addresses and for slaves that stop responding (timeout).

Parameters:
- NB_MASTER, 3, number of requesters.
- NB_SLAVE, 3, number of decoded regions.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for a slave response; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid_i  in  NB_MASTER  per-master request valid.
- req_ready_o  out  NB_MASTER  per-master request accepted; one-hot or zero.
- req_addr_i  in  NB_MASTER*ADDR_WIDTH  packed addresses; master k occupies slice k.
- req_we_i  in  NB_MASTER  1 = write.
- req_wdata_i  in  NB_MASTER*DATA_WIDTH  packed write data.
- resp_valid_o  out  NB_MASTER  response valid; only the owner's bit can be set.
- resp_ready_i  in  NB_MASTER  master accepts response.
- resp_rdata_o  out  DATA_WIDTH  read data, shared by all masters.
- resp_err_o  out  1  error flag, qualified by resp_valid_o.
- slv_req_valid_o  out  1  request to slave.
- slv_req_ready_i  in  1  slave accepts request.
- slv_sel_o  out  NB_SLAVE  one-hot region select.
- slv_addr_o  out  ADDR_WIDTH  latched address.
- slv_we_o  out  1  latched write flag.
- slv_wdata_o  out  DATA_WIDTH  latched write data.
- slv_resp_valid_i  in  1  slave response valid.
- slv_resp_ready_o  out  1  scheduler accepts slave response.
- slv_rdata_i  in  DATA_WIDTH  slave read data.
- slv_err_i  in  1  slave error.
- stray_resp_o  out  1  one-cycle pulse when a response arrives outside RESP state.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; RR pointer = 0.
  - All outputs 0, except slv_resp_ready_o = 1 (IDLE drains responses).
  - Latched addr/we/wdata/rdata/err/owner = 0; timeout counter = 0.
  - Asserting rst mid-transaction drops everything; no response is delivered.
- Address map, inclusive ranges:
  - region 0: 0x0000_0000–0x000F_FFFF
  - region 1: 0x0010_0000–0x001F_FFFF
  - region 2: 0x1A10_0000–0x1A11_FFFF
  - any other address is unmapped.
- IDLE:
  - Grant g = first master with req_valid_i set, searching from the RR pointer upward with wrap from NB_MASTER-1 to 0.
  - req_ready_o[g] = 1 in the same cycle (combinational from valid and state).
  - On that edge, latch addr/we/wdata/owner = g; pointer becomes (g+1) mod NB_MASTER.
  - Mapped address → REQ. Unmapped → DELIVER with err=1 and rdata=0.
  - No valid requests: stay in IDLE, pointer unchanged.
- REQ:
  - slv_req_valid_o = 1 and slv_sel_o = decoded one-hot; both held stable until slv_req_ready_i.
  - On handshake → RESP with timeout counter cleared.
  - No timeout applies in REQ.
- RESP:
  - slv_resp_ready_o = 1; counter increments each cycle.
  - On slv_resp_valid_i: latch rdata and err → DELIVER.
  - If the counter reaches TIMEOUT with no response → DELIVER with err=1 and rdata=0.
  - If the response and the timeout fall in the same cycle, the response wins.
- DELIVER:
  - resp_valid_o[owner] = 1; resp_rdata_o and resp_err_o held stable until resp_ready_i[owner].
  - On that handshake → IDLE.
  - slv_resp_ready_o = 1; a response accepted here, or in IDLE, is discarded and pulses stray_resp_o.
- Request-to-slave latency: 1 cycle after IDLE acceptance.
- Minimum transaction: 4 cycles (IDLE, REQ, RESP, DELIVER), with zero-wait slave and master.
- slv_sel_o = 0 outside REQ.

Decomposition:
- Package sched_pkg holds:
  - state enum {IDLE, REQ, RESP, DELIVER};
  - region start/end address constants;
  - function decode_region(addr) returning a one-hot value, 0 when unmapped.
- One sub-module, rr_arbiter, carries the arbitration:
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant, grant index, any_grant.

Test Plan:
- Priority and pointer: all three masters valid from reset, zero-wait slave → grant order 0,1,2,0; each slv_req_valid_o one cycle after its req_ready_o.
- Decode: master 1 reads 0x1A10_0004 → slv_sel_o=3'b100; slave returns 0xDEADBEEF → resp_valid_o=3'b010, rdata=0xDEADBEEF, err=0.
- Unmapped address: master 2 writes 0x2000_0000 → no slv_req_valid_o; resp_valid_o[2] one cycle after acceptance, err=1, rdata=0.
- Timeout: TIMEOUT=4, slave never responds → err=1 exactly 4 cycles after entering RESP. A slave response 2 cycles later in IDLE → stray_resp_o pulses once.
- Backpressure: slv_req_ready_i low for 5 cycles → addr/sel/we/wdata stable throughout. resp_ready_i low for 3 cycles → response held, no new grant during that time.
- Reset mid-operation: rst asserted during RESP → all outputs 0 immediately (asynchronously, without waiting for a clock edge), slv_resp_ready_o=1; after release, master 0 wins first.
